// File: rtl/axil_regfile_pkg.sv
// ---------------------------------------------------------------------------
// axil_regfile_pkg
//  Shared definitions for the AXI4-Lite register bank: response codes,
//  the response type, and the address-to-register-index decode helper.
// ---------------------------------------------------------------------------
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] axi_resp_t;

  // Result of decoding a byte address into a register slot.
  typedef struct packed {
    logic       in_range;
    logic [7:0] idx;
  } reg_sel_t;

  // Word index is addr[addr_w-1:2]; byte offset bits are ignored.
  // in_range is computed on the full index so aliasing above NUM_REGS
  // is reported as out of range rather than wrapping into the bank.
  function automatic reg_sel_t reg_index(input logic [31:0] addr,
                                         input int unsigned addr_w,
                                         input int unsigned num_regs);
    logic [31:0] mask;
    logic [31:0] word;
    reg_sel_t    sel;
    mask         = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
    word         = (addr & mask) >> 2;
    sel.in_range = (word < num_regs);
    sel.idx      = word[7:0];
    return sel;
  endfunction

endpackage

// File: rtl/axil_regfile_bank.sv
// ---------------------------------------------------------------------------
// axil_regfile_bank
//  Parametrised AXI4-Lite slave register bank with read-only registers,
//  self-clearing pulse registers, byte-strobe writes and per-register
//  write/read strobes for user logic.
//
// Ports
//  axi_aclk, axi_areset       clock, synchronous active-high reset
//  S_AXI_AW* / S_AXI_W*       write address / data channels (AWPROT ignored)
//  S_AXI_B*                   write response (OKAY / SLVERR)
//  S_AXI_AR* / S_AXI_R*       read address / data channels (ARPROT ignored)
//  slv_reg                    register contents to user logic
//  slv_read                   read-back source for read-only registers
//  reg_wr_pulse/reg_rd_pulse  one-cycle per-register write / read strobes
// ---------------------------------------------------------------------------
module axil_regfile_bank
  import axil_regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]             PULSE_MASK = '0,
  parameter logic [NUM_REGS-1:0][DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                             axi_aclk,
  input  logic                             axi_areset,
  input  logic [ADDR_W-1:0]                S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [DATA_W-1:0]                S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]              S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [ADDR_W-1:0]                S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [DATA_W-1:0]                S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  slv_reg,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  slv_read,
  output logic [NUM_REGS-1:0]              reg_wr_pulse,
  output logic [NUM_REGS-1:0]              reg_rd_pulse
);

  localparam int STRB_W = DATA_W / 8;

  // Keeps all READY outputs low while in reset and for the first cycle out.
  logic                             rst_done_reg;

  // Write path state
  logic                             aw_held_reg;
  logic [ADDR_W-1:0]                aw_addr_reg;
  logic                             w_held_reg;
  logic [DATA_W-1:0]                w_data_reg;
  logic [STRB_W-1:0]                w_strb_reg;
  logic                             bvalid_reg;
  axi_resp_t                        bresp_reg;
  logic [NUM_REGS-1:0]              wr_pulse_reg;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_reg;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_next;

  // Read path state
  logic                             rvalid_reg;
  axi_resp_t                        rresp_reg;
  logic [DATA_W-1:0]                rdata_reg;
  logic [NUM_REGS-1:0]              rd_pulse_reg;

  logic                             aw_hs;
  logic                             w_hs;
  logic                             ar_hs;
  logic                             commit;
  logic [ADDR_W-1:0]                commit_addr;
  logic [DATA_W-1:0]                commit_data;
  logic [STRB_W-1:0]                commit_strb;
  reg_sel_t                         wr_sel;
  reg_sel_t                         rd_sel;
  logic [NUM_REGS-1:0]              wr_hit_vec;
  logic [NUM_REGS-1:0]              rd_hit_vec;
  logic [DATA_W-1:0]                rd_value;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY = rst_done_reg && !aw_held_reg && !bvalid_reg;
  assign S_AXI_WREADY  = rst_done_reg && !w_held_reg  && !bvalid_reg;
  assign S_AXI_ARREADY = rst_done_reg && !rvalid_reg;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A held beat takes priority; otherwise use the beat handshaking now.
  assign commit_addr = aw_held_reg ? aw_addr_reg : S_AXI_AWADDR;
  assign commit_data = w_held_reg  ? w_data_reg  : S_AXI_WDATA;
  assign commit_strb = w_held_reg  ? w_strb_reg  : S_AXI_WSTRB;
  assign commit      = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

  assign wr_sel = reg_index(32'(commit_addr), ADDR_W, NUM_REGS);
  assign rd_sel = reg_index(32'(S_AXI_ARADDR), ADDR_W, NUM_REGS);

  // Per-register next-state and address-hit decode.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic              wr_hit;
    logic [DATA_W-1:0] nxt;

    assign wr_hit         = commit && wr_sel.in_range && (wr_sel.idx == 8'(gi));
    assign wr_hit_vec[gi] = wr_hit;
    assign rd_hit_vec[gi] = rd_sel.in_range && (rd_sel.idx == 8'(gi));

    // Pulse registers fall back to zero every cycle unless written again,
    // so a fresh write always wins over the self-clear.
    always_comb begin
      nxt = PULSE_MASK[gi] ? '0 : regs_reg[gi];
      if (wr_hit && !RO_MASK[gi]) begin
        nxt = regs_reg[gi];
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_strb[b]) begin
            nxt[8*b +: 8] = commit_data[8*b +: 8];
          end
        end
      end
    end

    assign regs_next[gi] = nxt;
  end

  // Read data mux; out-of-range addresses return zero.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit_vec[i]) begin
        rd_value = RO_MASK[i] ? slv_read[i] : regs_reg[i];
      end
    end
  end

  // Write path: AW/W holds, commit, B channel and register storage.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rst_done_reg <= 1'b0;
      aw_held_reg  <= 1'b0;
      aw_addr_reg  <= '0;
      w_held_reg   <= 1'b0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      wr_pulse_reg <= '0;
      regs_reg     <= RESET_VAL;
    end else begin
      rst_done_reg <= 1'b1;
      regs_reg     <= regs_next;
      wr_pulse_reg <= '0;
      if (bvalid_reg && S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      if (commit) begin
        aw_held_reg  <= 1'b0;
        w_held_reg   <= 1'b0;
        bvalid_reg   <= 1'b1;
        bresp_reg    <= wr_sel.in_range ? RESP_OKAY : RESP_SLVERR;
        wr_pulse_reg <= wr_hit_vec;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= S_AXI_WDATA;
          w_strb_reg <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Read path: data is sampled at the AR handshake edge, so a write
  // committing on the same edge is not yet visible.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
      rd_pulse_reg <= '0;
    end else begin
      rd_pulse_reg <= '0;
      if (rvalid_reg && S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_reg   <= 1'b1;
        rresp_reg    <= rd_sel.in_range ? RESP_OKAY : RESP_SLVERR;
        rdata_reg    <= rd_value;
        rd_pulse_reg <= rd_hit_vec;
      end
    end
  end

  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = bresp_reg;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RRESP  = rresp_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign slv_reg      = regs_reg;
  assign reg_wr_pulse = wr_pulse_reg;
  assign reg_rd_pulse = rd_pulse_reg;

endmodule

// File: tb/tb_axil_regfile_bank.sv
// ---------------------------------------------------------------------------
// tb_axil_regfile_bank
//  Directed test of axil_regfile_bank with NUM_REGS=16, reg 0 read-only,
//  reg 3 a pulse register, and reg 5 reset to 0x0000CAFE.
// ---------------------------------------------------------------------------
module tb_axil_regfile_bank;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam logic [NR-1:0]         RO = 16'h0001;
  localparam logic [NR-1:0]         PM = 16'h0008;
  localparam logic [NR-1:0][DW-1:0] RV = (512'h0000CAFE << 160);

  logic                  clk;
  logic                  srst;
  logic [AW-1:0]         awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DW-1:0]         wdata;
  logic [DW/8-1:0]       wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AW-1:0]         araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [NR-1:0][DW-1:0] slv_reg;
  logic [NR-1:0][DW-1:0] slv_read;
  logic [NR-1:0]         wr_pulse;
  logic [NR-1:0]         rd_pulse;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_reg [NR];

  axil_regfile_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW),
    .RO_MASK(RO), .PULSE_MASK(PM), .RESET_VAL(RV)
  ) dut (
    .axi_aclk(clk),           .axi_areset(srst),
    .S_AXI_AWADDR(awaddr),    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),  .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),      .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),      .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),  .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),      .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),    .S_AXI_RREADY(rready),
    .slv_reg(slv_reg),        .slv_read(slv_read),
    .reg_wr_pulse(wr_pulse),  .reg_rd_pulse(rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), slv_reg[i], exp_reg[i]);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
    for (int n = 0; n < 20 && !(awready && wready); n++) tick();
    chk("wr_ready_wait", {31'd0, awready && wready}, 32'd1);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_after_commit", {31'd0, bvalid}, 32'd1);
    resp  = bresp;
    pulse = wr_pulse;
    $display("write addr=%h data=%h strb=%h -> bresp=%0d pulse=%h", a, d, s, resp, pulse);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_cleared", {31'd0, bvalid}, 32'd0);
    chk("wr_pulse_one_cycle", {16'd0, wr_pulse}, 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output logic [15:0] pulse);
    for (int n = 0; n < 20 && !arready; n++) tick();
    chk("rd_ready_wait", {31'd0, arready}, 32'd1);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("rvalid_after_ar", {31'd0, rvalid}, 32'd1);
    d     = rdata;
    resp  = rresp;
    pulse = rd_pulse;
    $display("read  addr=%h -> rdata=%h rresp=%0d pulse=%h", a, d, resp, pulse);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_cleared", {31'd0, rvalid}, 32'd0);
    chk("rd_pulse_one_cycle", {16'd0, rd_pulse}, 32'd0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] d;

    srst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      slv_read[i] = 32'h1000_0000 + 32'(i);
      exp_reg[i]  = 32'd0;
    end
    slv_read[0] = 32'hDEAD_BEEF;
    exp_reg[5]  = 32'h0000_CAFE;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    srst = 1'b0;
    tick();
    chk("idle_awready", {31'd0, awready}, 32'd1);
    chk("idle_wready",  {31'd0, wready},  32'd1);
    chk("idle_arready", {31'd0, arready}, 32'd1);
    check_regs("rst");
    $display("reset released");

    // AW+W same cycle, full strobe
    do_write(8'h08, 32'hA5A5_0003, 4'hF, resp, pulse);
    exp_reg[2] = 32'hA5A5_0003;
    chk("t1_bresp", {30'd0, resp}, 32'd0);
    chk("t1_pulse", {16'd0, pulse}, 32'h0004);
    chk("t1_reg2", slv_reg[2], 32'hA5A5_0003);

    // W three cycles ahead of AW, single byte lane
    do_write(8'h10, 32'h1122_3344, 4'hF, resp, pulse);
    exp_reg[4] = 32'h1122_3344;
    chk("t2_pre_reg4", slv_reg[4], 32'h1122_3344);
    wdata = 32'h0000_BB00; wstrb = 4'h2; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    chk("t2_wready_held", {31'd0, wready},  32'd0);
    chk("t2_awready",     {31'd0, awready}, 32'd1);
    tick();
    tick();
    chk("t2_no_bvalid",   {31'd0, bvalid},  32'd0);
    chk("t2_reg4_wait",   slv_reg[4], 32'h1122_3344);
    awaddr = 8'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    exp_reg[4] = 32'h1122_BB44;
    chk("t2_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t2_reg4",   slv_reg[4], 32'h1122_BB44);
    chk("t2_pulse",  {16'd0, wr_pulse}, 32'h0010);
    $display("write addr=10 W-first strb=2 -> reg4=%h", slv_reg[4]);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Read-only register
    do_write(8'h00, 32'h1234_5678, 4'hF, resp, pulse);
    chk("t3_bresp", {30'd0, resp}, 32'd0);
    chk("t3_pulse", {16'd0, pulse}, 32'h0001);
    chk("t3_reg0",  slv_reg[0], 32'd0);
    do_read(8'h00, d, resp, pulse);
    chk("t3_rdata", d, 32'hDEAD_BEEF);
    chk("t3_rresp", {30'd0, resp}, 32'd0);
    chk("t3_rpulse", {16'd0, pulse}, 32'h0001);

    // Plain read-back
    do_read(8'h08, d, resp, pulse);
    chk("rb_rdata",  d, 32'hA5A5_0003);
    chk("rb_rpulse", {16'd0, pulse}, 32'h0004);

    // Out-of-range address
    do_write(8'h40, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    chk("t4_bresp", {30'd0, resp}, 32'd2);
    chk("t4_pulse", {16'd0, pulse}, 32'd0);
    do_read(8'h40, d, resp, pulse);
    chk("t4_rresp",  {30'd0, resp}, 32'd2);
    chk("t4_rdata",  d, 32'd0);
    chk("t4_rpulse", {16'd0, pulse}, 32'd0);
    check_regs("t4");

    // Zero strobe
    do_write(8'h18, 32'hFFFF_FFFF, 4'h0, resp, pulse);
    chk("strb0_bresp", {30'd0, resp}, 32'd0);
    chk("strb0_pulse", {16'd0, pulse}, 32'h0040);
    chk("strb0_reg6",  slv_reg[6], 32'd0);

    // Pulse register, read on the commit edge
    awaddr = 8'h0C; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5_reg3_set",  slv_reg[3], 32'd5);
    chk("t5_rvalid",    {31'd0, rvalid}, 32'd1);
    chk("t5_rdata_old", rdata, 32'd0);
    chk("t5_rpulse",    {16'd0, rd_pulse}, 32'h0008);
    chk("t5_wpulse",    {16'd0, wr_pulse}, 32'h0008);
    $display("pulse write addr=0C data=5 -> reg3=%h, same-edge read=%h", slv_reg[3], rdata);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("t5_reg3_clear", slv_reg[3], 32'd0);
    chk("t5_bvalid_clr", {31'd0, bvalid}, 32'd0);

    // Backpressure, then reset mid-wait
    awaddr = 8'h14; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h14; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("t6_bvalid",  {31'd0, bvalid},  32'd1);
      chk("t6_bresp",   {30'd0, bresp},   32'd0);
      chk("t6_awready", {31'd0, awready}, 32'd0);
      chk("t6_wready",  {31'd0, wready},  32'd0);
      chk("t6_rvalid",  {31'd0, rvalid},  32'd1);
      chk("t6_rdata",   rdata,            32'h0000_CAFE);
      chk("t6_arready", {31'd0, arready}, 32'd0);
      chk("t6_reg5",    slv_reg[5],       32'h0BAD_F00D);
      $display("stall cycle %0d bvalid=%0d rvalid=%0d rdata=%h", c, bvalid, rvalid, rdata);
      tick();
    end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int i = 0; i < NR; i++) exp_reg[i] = 32'd0;
    exp_reg[5] = 32'h0000_CAFE;
    chk("t6_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("t6_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("t6_rst_rdata",  rdata, 32'd0);
    chk("t6_rst_awready", {31'd0, awready}, 32'd0);
    check_regs("t6_rst");
    tick();
    chk("t6_post_awready", {31'd0, awready}, 32'd1);
    chk("t6_post_arready", {31'd0, arready}, 32'd1);
    $display("reset mid-wait cleared pending responses");
    do_read(8'h14, d, resp, pulse);
    chk("t6_post_rdata", d, 32'h0000_CAFE);
    do_read(8'h08, d, resp, pulse);
    chk("t6_post_reg2",  d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
